// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C slave that receives one 16-bit word per transfer.
// Frame: START, {DEV_ADDR,W}, high byte, low byte, STOP. All three bytes are ACKed.
// Any bytes after the low byte are NACKed and dropped.
// Optional build macro: I2C_SLAVE_RX_GLITCH_FILTER_EN adds a 3-CLK stability filter
// behind each input synchronizer. Without the macro the synchronized levels are used directly.
module i2c_slave_rx #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] data,
    output logic        valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        DHI    = 3'd3,
        ACK_H  = 3'd4,
        DLO    = 3'd5,
        ACK_L  = 3'd6,
        IGNORE = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_lvl;
    logic       sda_lvl;

    // Two-flop synchronizers; they reset to the idle bus level (high)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

`ifdef I2C_SLAVE_RX_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_flt;
    logic       sda_flt;

    // Filtered level follows the synchronizer only once it has held the same
    // value for three consecutive CLKs, so single-CLK spikes never reach the FSM
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_flt  <= 1'b1;
            sda_flt  <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            if ((scl_sync[1] == scl_hist[0]) && (scl_hist[0] == scl_hist[1]))
                scl_flt <= scl_hist[0];
            if ((sda_sync[1] == sda_hist[0]) && (sda_hist[0] == sda_hist[1]))
                sda_flt <= sda_hist[0];
        end
    end

    assign scl_lvl = scl_flt;
    assign sda_lvl = sda_flt;
`else
    assign scl_lvl = scl_sync[1];
    assign sda_lvl = sda_sync[1];
`endif

    // ------------------------------------------------------------------
    // Bus event detection
    // ------------------------------------------------------------------
    logic scl_d;
    logic sda_d;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    // One-CLK delayed copies of the conditioned levels for edge detection
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_lvl;
            sda_d <= sda_lvl;
        end
    end

    assign scl_rise  =  scl_lvl & ~scl_d;
    assign scl_fall  = ~scl_lvl &  scl_d;
    // SDA may only move while SCL is low during data; a move with SCL high is a condition
    assign start_det =  scl_lvl &  scl_d &  sda_d & ~sda_lvl;
    assign stop_det  =  scl_lvl &  scl_d & ~sda_d &  sda_lvl;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] hi_byte;
    logic [7:0] byte_in;
    logic       sda_oe;
    logic       ack_on;

    // Byte completed by the bit being sampled on this SCL rise
    assign byte_in = {shreg, sda_lvl};

    // Open-drain: only ever pull low or release
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Frame decoder with registered outputs; STOP outranks START outranks bit traffic
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shreg   <= 7'd0;
            hi_byte <= 8'd0;
            data    <= 16'h0000;
            valid   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            sda_oe  <= 1'b0;
            ack_on  <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (stop_det) begin
                // Frame ended before the word was delivered; IGNORE and ACK_L are clean ends
                if (state inside {ADDR, ACK_A, DHI, ACK_H, DLO})
                    err <= 1'b1;
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
            end else if (start_det) begin
                // Fresh or repeated START: drop any partial byte and re-arm for the address
                state   <= ADDR;
                busy    <= 1'b1;
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= 3'd0;
            end else begin
                case (state)
                    ADDR, DHI, DLO: begin
                        if (scl_rise) begin
                            shreg   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (state)
                                    ADDR: begin
                                        // Only a write to our address is accepted; reads count as mismatches
                                        if (byte_in == {DEV_ADDR, 1'b0}) begin
                                            state <= ACK_A;
                                        end else begin
                                            err   <= 1'b1;
                                            state <= IGNORE;
                                        end
                                    end
                                    DHI: begin
                                        hi_byte <= byte_in;
                                        state   <= ACK_H;
                                    end
                                    default: begin
                                        data  <= {hi_byte, byte_in};
                                        valid <= 1'b1;
                                        state <= ACK_L;
                                    end
                                endcase
                            end
                        end
                    end
                    ACK_A, ACK_H, ACK_L: begin
                        // First fall after bit 8 starts the ACK, the fall after the 9th clock ends it
                        if (scl_fall) begin
                            if (!ack_on) begin
                                sda_oe <= 1'b1;
                                ack_on <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                ack_on  <= 1'b0;
                                bit_cnt <= 3'd0;
                                case (state)
                                    ACK_A:   state <= DHI;
                                    ACK_H:   state <= DLO;
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    default: ;  // IDLE waits for START, IGNORE waits for STOP/START
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: bit-banged I2C master driving i2c_slave_rx.
// A transfer-level model predicts ACKs, the delivered word, valid and err counts.
module tb_i2c_slave_rx;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        scl   = 1'b1;
    logic        m_low = 1'b0;
    wire         sda_w;
    logic [15:0] data;
    logic        valid;
    logic        busy;
    logic        err;

    pullup (sda_w);
    assign sda_w = m_low ? 1'b0 : 1'bz;

    i2c_slave_rx #(.DEV_ADDR(7'h1A)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .scl   (scl),
        .sda   (sda_w),
        .data  (data),
        .valid (valid),
        .busy  (busy),
        .err   (err)
    );

    always #5 CLK = ~CLK;

    // Pulse / bus monitors, sampled away from the active edge
    int n_valid  = 0;
    int n_err    = 0;
    int n_both   = 0;
    int n_dutlow = 0;
    always @(negedge CLK) begin
        if (valid === 1'b1) n_valid++;
        if (err === 1'b1) n_err++;
        if (valid === 1'b1 && err === 1'b1) n_both++;
        if (!m_low && sda_w === 1'b0) n_dutlow++;
    end

    // Model state and bookkeeping
    logic [15:0] exp_data;
    int          exp_valid;
    int          exp_err;
    logic        seg_pend;
    int          n_chk;
    int          n_fail;
    logic [7:0]  bq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic qwait();
        repeat (8) @(negedge CLK);
    endtask

    task automatic bit_out(input logic b, input logic glitch);
        m_low = ~b;
        if (glitch) begin
            repeat (3) @(negedge CLK);
            scl = 1'b1;
            @(negedge CLK);
            scl = 1'b0;
            repeat (4) @(negedge CLK);
        end else begin
            qwait();
        end
        scl = 1'b1;
        qwait();
        qwait();
        scl = 1'b0;
        qwait();
    endtask

    task automatic byte_out(input logic [7:0] b, input logic glitch_b4);
        for (int k = 7; k >= 0; k--) bit_out(b[k], glitch_b4 && (k == 4));
    endtask

    // Ninth clock; returns the sampled SDA (0 = ACK)
    task automatic ack_clk(output logic a);
        m_low = 1'b0;
        qwait();
        scl = 1'b1;
        qwait();
        a = sda_w;
        qwait();
        scl = 1'b0;
        qwait();
    endtask

    // START from idle, or repeated START when SCL is low
    task automatic do_start();
        if (scl == 1'b0) begin
            m_low = 1'b0;
            qwait();
            scl = 1'b1;
            qwait();
        end
        m_low = 1'b1;
        qwait();
        scl = 1'b0;
        qwait();
        seg_pend = 1'b0;
    endtask

    task automatic do_stop(input string tag);
        m_low = 1'b1;
        qwait();
        scl = 1'b1;
        qwait();
        m_low = 1'b0;
        qwait();
        qwait();
        if (seg_pend) exp_err++;
        seg_pend = 1'b0;
        chk({tag, "_busy_after_stop"}, busy, 0);
    endtask

    // One START-delimited segment carrying the bytes in bq
    task automatic seg(input string tag, input int glitch_byte);
        logic matched;
        logic expect_ack;
        logic a;
        do_start();
        chk({tag, "_busy_after_start"}, busy, 1);
        matched = 1'b0;
        foreach (bq[i]) begin
            if (i == 0) begin
                matched = (bq[0] == 8'h34);
                if (!matched) exp_err++;
                expect_ack = matched;
            end else begin
                expect_ack = matched && (i <= 2);
            end
            if (matched && i == 2) begin
                exp_data = {bq[1], bq[2]};
                exp_valid++;
            end
            byte_out(bq[i], i == glitch_byte);
            ack_clk(a);
            chk({tag, "_ack"}, a, {31'd0, ~expect_ack});
        end
        seg_pend = matched && (bq.size() < 3);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_data"}, data, exp_data);
        chk({tag, "_valid_count"}, n_valid, exp_valid);
        chk({tag, "_err_count"}, n_err, exp_err);
    endtask

    initial begin
        logic       a;
        logic [7:0] ra;
        int         nb;
        int         base;

        exp_data  = 16'h0000;
        exp_valid = 0;
        exp_err   = 0;
        seg_pend  = 1'b0;
        n_chk     = 0;
        n_fail    = 0;

        // Reset state
        #1;
        chk("rst_data", data, 16'h0000);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_sda", sda_w, 1);
        repeat (4) @(negedge CLK);
        RST_N = 1'b1;
        repeat (8) @(negedge CLK);
        chk("idle_busy", busy, 0);

        // Plain full write
        bq = {8'h34, 8'h1E, 8'h00};
        seg("t1", -1);
        do_stop("t1");
        check_all("t1");
        chk("t1_data_word", data, 16'h1E00);

        // Wrong address: no drive from the block at all
        base = n_dutlow;
        bq = {8'h36};
        seg("t2", -1);
        do_stop("t2");
        check_all("t2");
        chk("t2_no_sda_drive", n_dutlow - base, 0);

        // Truncated transfer
        bq = {8'h34, 8'h1E};
        seg("t3", -1);
        do_stop("t3");
        check_all("t3");

        // Repeated START mid-transfer, then an extra byte
        bq = {8'h34, 8'hAA};
        seg("t4a", -1);
        bq = {8'h34, 8'h0A, 8'h55, 8'h77};
        seg("t4b", -1);
        do_stop("t4");
        check_all("t4");
        chk("t4_data_word", data, 16'h0A55);

        // Reset while the block is ACKing the high byte
        do_start();
        byte_out(8'h34, 1'b0);
        ack_clk(a);
        chk("t5_ack_addr", a, 0);
        byte_out(8'h1E, 1'b0);
        m_low = 1'b0;
        @(negedge CLK);
        chk("t5_ack_h_driven", sda_w, 0);
        #2 RST_N = 1'b0;
        #1;
        chk("t5_rst_sda", sda_w, 1);
        chk("t5_rst_data", data, 16'h0000);
        chk("t5_rst_valid", valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_err", err, 0);
        exp_data = 16'h0000;
        @(negedge CLK);
        RST_N = 1'b1;
        ack_clk(a);
        chk("t5_post_rst_nack", a, 1);
        byte_out(8'h34, 1'b0);
        ack_clk(a);
        chk("t5_no_start_nack", a, 1);
        do_stop("t5");
        check_all("t5_ignored");
        bq = {8'h34, 8'h5C, 8'h3E};
        seg("t5b", -1);
        do_stop("t5b");
        check_all("t5b");
        chk("t5b_data_word", data, 16'h5C3E);

        // Random frames: random address (half matching) and 0..4 trailing bytes
        for (int t = 0; t < 6; t++) begin
            bq = {};
            if ($urandom_range(0, 1) == 1) begin
                bq.push_back(8'h34);
            end else begin
                ra = 8'($urandom_range(0, 255));
                if (ra == 8'h34) ra = 8'h35;
                bq.push_back(ra);
            end
            nb = $urandom_range(0, 4);
            for (int k = 0; k < nb; k++) bq.push_back(8'($urandom_range(0, 255)));
            seg("rand", -1);
            do_stop("rand");
            check_all("rand");
        end

`ifdef I2C_SLAVE_RX_GLITCH_FILTER_EN
        // One-CLK SCL spike inside a data bit must not add a bit
        bq = {8'h34, 8'hA5, 8'h3C};
        seg("glitch", 1);
        do_stop("glitch");
        check_all("glitch");
        chk("glitch_data_word", data, 16'hA53C);
`endif

        chk("valid_err_overlap", n_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit device address it responds to (write byte 8'h34).
REQ-002 SHALL have port CLK, input, 1 bit: the single system clock, at least 16x the SCL frequency.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port scl, input, 1 bit: I2C serial clock from the bus master.
REQ-005 SHALL have port sda, inout, 1 bit: I2C serial data, open-drain (the block drives only 1'b0 or 1'bz).
REQ-006 SHALL have port data, output, 16 bits: last completed word, high byte received first.
REQ-007 SHALL have port valid, output, 1 bit: one-CLK pulse when data updates.
REQ-008 SHALL have port busy, output, 1 bit: high from START detect until return to IDLE.
REQ-009 SHALL have port err, output, 1 bit: one-CLK pulse on address mismatch, read request, or aborted transfer.

Function
REQ-010 SHALL pass scl and sda through 2-FF synchronizers reset to 1; all detection uses the synchronized levels (2 CLK latency).
REQ-011 SHALL detect START as a sync-SDA falling edge while sync-SCL is high, and STOP as a sync-SDA rising edge while sync-SCL is high.
REQ-012 SHALL sample SDA on each sync-SCL rising edge, MSB first, and change the sda drive only after a sync-SCL falling edge.
REQ-013 SHALL implement states IDLE, ADDR, ACK_A, DHI, ACK_H, DLO, ACK_L, IGNORE.
REQ-014 SHALL move from IDLE, or from any state, to ADDR on START (repeated START restarts the transfer, discarding partial bytes, without err).
REQ-015 SHALL, after 8 address bits, go to ACK_A if the bits equal {DEV_ADDR,1'b0}; otherwise pulse err, leave sda released, and go to IGNORE.
REQ-016 SHALL, in ACK_A/ACK_H/ACK_L, drive sda low from the SCL falling edge after bit 8 until the SCL falling edge after the 9th clock.
REQ-017 SHALL go ACK_A->DHI->ACK_H->DLO->ACK_L->IGNORE, with 8 bits per data state.
REQ-018 SHALL update data and pulse valid one CLK after the sync-SCL rising edge that samples bit 0 of the low byte.
REQ-019 SHALL not ACK bytes received in IGNORE, and SHALL hold data unchanged there.
REQ-020 SHALL go to IDLE on STOP from any state; STOP before valid but after ADDR started pulses err; STOP in IGNORE does not.
REQ-021 SHALL drive busy high in every state except IDLE.
REQ-022 SHALL keep data stable between valid pulses; valid and err never pulse in the same CLK.

Reset
REQ-023 SHALL on RST_N low immediately set state IDLE, data 16'h0000, valid 0, busy 0, err 0, sda released (z), synchronizers 1.
REQ-024 SHALL, after a mid-transfer reset, ignore bus activity until the next START.

Configuration
REQ-025 SHALL, when I2C_SLAVE_RX_GLITCH_FILTER_EN is defined, add a filter after each synchronizer that changes its output only after the input is stable for 3 consecutive CLKs (total latency 5 CLK).
REQ-026 SHALL, when I2C_SLAVE_RX_GLITCH_FILTER_EN is undefined, omit the filter, and behave otherwise identically.

Verification
REQ-027 SHALL be verified with START, 8'h34, 8'h1E, 8'h00, STOP -> three ACKs, data=16'h1E00, one valid pulse, busy low after STOP.
REQ-028 SHALL be verified with START, 8'h36, STOP -> no ACK, sda never driven low by the block, one err pulse, no valid.
REQ-029 SHALL be verified with START, 8'h34, 8'h1E, STOP -> two ACKs, no valid, one err pulse, data unchanged.
REQ-030 SHALL be verified with START, 8'h34, 8'hAA, repeated START, 8'h34, 8'h0A, 8'h55, 8'h77, STOP -> data=16'h0A55, one valid pulse, 8'h77 NACKed.
REQ-031 SHALL be verified with RST_N pulsed low during ACK_H -> sda released in the same cycle, all outputs at reset values, and the next full write succeeds.
REQ-032 SHALL be verified with the macro defined and a 1-CLK SCL high glitch during a data bit -> bit count unaffected and data correct.
